// File: rtl/walu_res_fifo.sv
// rtl/walu_res_fifo.sv - first-word-fall-through result FIFO for walu results
//
// Captures {in_cout, in_data} from the walu through a valid/ready handshake
// and re-presents entries in order at out_*. Also reports occupancy, a
// high-water mark and a sticky upstream protocol-violation flag.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake; in_data/in_cout = result word
//   out_valid/out_ready    downstream handshake; out_data/out_cout = head entry
//   count                  current occupancy, 0..DEPTH
//   hwm                    highest occupancy reached since reset
//   proto_err              sticky: a stalled request was dropped or changed

module walu_res_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_cout,
    output logic [CNT_W-1:0]      count,
    output logic [CNT_W-1:0]      hwm,
    output logic                  proto_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH:0]   head;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      count_next;

    // Registered copy of last cycle's upstream request for the monitor
    logic                  prev_valid;
    logic                  prev_ready;
    logic [DATA_WIDTH-1:0] prev_data;
    logic                  prev_cout;
    logic                  violation;

    // in_ready looks only at count, so a pop while full frees the slot for
    // the following cycle rather than the current one.
    assign in_ready  = (count != CNT_W'(DEPTH)) && !rst;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head     = mem[rd_ptr];
    assign out_data = head[DATA_WIDTH-1:0];
    assign out_cout = head[DATA_WIDTH];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // A request stalled last cycle must still be present and unchanged now.
    assign violation = prev_valid && !prev_ready &&
                       (!in_valid || (in_data != prev_data) || (in_cout != prev_cout));

    // Array contents are deliberately not reset; only pointers are.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_cout, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hwm        <= '0;
            proto_err  <= 1'b0;
            prev_valid <= 1'b0;
            prev_ready <= 1'b0;
            prev_data  <= '0;
            prev_cout  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            if (count_next > hwm) begin
                hwm <= count_next;
            end
            if (violation) begin
                proto_err <= 1'b1;
            end
            prev_valid <= in_valid;
            prev_ready <= in_ready;
            prev_data  <= in_data;
            prev_cout  <= in_cout;
        end
    end

endmodule
